adc_serial_rx: RTL and testbench

//  Serial front end for the external 10-bit SPI-style ADC. On each start request it frames one conversion:

---
 rtl/adc_serial_pkg.sv | 20 ++
 rtl/adc_sclk_gen.sv | 39 +++
 rtl/adc_serial_rx.sv | 195 +++++++++++++++++++
 tb/tb_adc_serial_rx.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_serial_pkg.sv
// Shared definitions for the ADC serial receiver.
// Contents:
//   DEF_*        default values for CLK_DIV, FRAME_BITS, LEAD_BITS, DATA_WIDTH
//   adc_state_t  frame sequencer states
package adc_serial_pkg;

   localparam int unsigned DEF_CLK_DIV    = 4;
   localparam int unsigned DEF_FRAME_BITS = 16;
   localparam int unsigned DEF_LEAD_BITS  = 3;
   localparam int unsigned DEF_DATA_WIDTH = 10;

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SHIFT,
      DONE,
      QUIET
   } adc_state_t;

endpackage

// File: rtl/adc_sclk_gen.sv
// Half-period timer for the ADC serial clock.
// Produces a one-cycle tick every CLK_DIV clk cycles while enabled. The count
// restarts from zero whenever the block is disabled.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous, active-high reset
//   en    in   run the half-period counter
//   tick  out  one-cycle pulse at the end of each CLK_DIV-cycle half period
module adc_sclk_gen
   import adc_serial_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;

   always_comb begin
      tick = en && (cnt_q == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/adc_serial_rx.sv
// Serial front end for the external SPI-style ADC.
// A start request in IDLE frames one conversion: chip select low, one setup
// half period, FRAME_BITS sclk cycles (low half then high half), a one-cycle
// DONE with the ready pulse, then a quiet gap of two half periods.
// adc_miso is captured on the clk edge where sclk rises; only bits
// LEAD_BITS..LEAD_BITS+DATA_WIDTH-1 of the frame enter the sample, MSB first.
// Build option: ADC_AVG_EN -- sample becomes the truncated mean of the last
// four captures (history cleared by reset); otherwise the raw capture.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   start     in   conversion request, only looked at in IDLE
//   adc_miso  in   ADC serial data
//   adc_cs_n  out  ADC chip select, active low
//   adc_sclk  out  ADC serial clock, idles high
//   sample    out  last sample, changes only in the ready cycle
//   ready     out  one-cycle pulse when sample updates
//   busy      out  high whenever not IDLE
module adc_serial_rx
   import adc_serial_pkg::*;
#(
   parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
   parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
   parameter int unsigned LEAD_BITS  = DEF_LEAD_BITS,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  adc_miso,
   output logic                  adc_cs_n,
   output logic                  adc_sclk,
   output logic [DATA_WIDTH-1:0] sample,
   output logic                  ready,
   output logic                  busy
);

   localparam int unsigned BW = $clog2(FRAME_BITS);
   localparam int unsigned QW = $clog2(2 * CLK_DIV);
   localparam logic [BW-1:0] LAST_BIT   = BW'(FRAME_BITS - 1);
   localparam logic [BW-1:0] FIRST_DATA = BW'(LEAD_BITS);
   localparam logic [BW-1:0] LAST_DATA  = BW'(LEAD_BITS + DATA_WIDTH - 1);
   localparam logic [QW-1:0] QUIET_LAST = QW'(2 * CLK_DIV - 1);

   adc_state_t state_q, state_d;

   logic                  sclk_q;
   logic [BW-1:0]         bit_q;
   logic [QW-1:0]         quiet_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] sample_q;
   logic [DATA_WIDTH-1:0] sample_next;

   logic tick;
   logic tick_en;
   logic sclk_rise;
   logic sclk_fall;
   logic bit_adv;
   logic frame_end;
   logic capture;

   adc_sclk_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_sclk_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (tick_en),
      .tick (tick)
   );

   // The half-period timer runs continuously from CS_SETUP through SHIFT, so
   // every tick marks an sclk edge: the setup tick drops sclk for bit 0, a tick
   // with sclk low raises it (capture point), a tick with sclk high either
   // starts the next bit or closes the frame.
   always_comb begin
      state_d   = state_q;
      tick_en   = 1'b0;
      sclk_rise = 1'b0;
      sclk_fall = 1'b0;
      bit_adv   = 1'b0;
      frame_end = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = CS_SETUP;
         end
         CS_SETUP: begin
            tick_en = 1'b1;
            if (tick) begin
               sclk_fall = 1'b1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            tick_en = 1'b1;
            if (tick) begin
               if (!sclk_q) begin
                  sclk_rise = 1'b1;
               end else if (bit_q == LAST_BIT) begin
                  frame_end = 1'b1;
                  state_d   = DONE;
               end else begin
                  sclk_fall = 1'b1;
                  bit_adv   = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = QUIET;
         end
         QUIET: begin
            if (quiet_q == QUIET_LAST) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      capture  = sclk_rise && (bit_q >= FIRST_DATA) && (bit_q <= LAST_DATA);
      adc_sclk = sclk_q;
      adc_cs_n = !((state_q == CS_SETUP) || (state_q == SHIFT));
      busy     = (state_q != IDLE);
      ready    = (state_q == DONE);
      sample   = sample_q;
   end

`ifdef ADC_AVG_EN
   logic [DATA_WIDTH-1:0] hist_q [3];
   logic [DATA_WIDTH+1:0] avg_sum;

   // Mean of the new capture and the three before it; DATA_WIDTH+2 bits
   // cannot overflow for four operands.
   always_comb begin
      avg_sum     = {2'b00, data_q} + {2'b00, hist_q[0]} +
                    {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
      sample_next = avg_sum[DATA_WIDTH+1:2];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 3; i++) hist_q[i] <= '0;
      end else if (frame_end) begin
         hist_q[0] <= data_q;
         hist_q[1] <= hist_q[0];
         hist_q[2] <= hist_q[1];
      end
   end
`else
   always_comb begin
      sample_next = data_q;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sclk_q   <= 1'b1;
         bit_q    <= '0;
         quiet_q  <= '0;
         data_q   <= '0;
         sample_q <= '0;
      end else begin
         state_q <= state_d;

         if (sclk_fall) begin
            sclk_q <= 1'b0;
         end else if (sclk_rise) begin
            sclk_q <= 1'b1;
         end

         if (frame_end) begin
            bit_q <= '0;
         end else if (bit_adv) begin
            bit_q <= bit_q + 1'b1;
         end

         if (state_q == QUIET && quiet_q != QUIET_LAST) begin
            quiet_q <= quiet_q + 1'b1;
         end else begin
            quiet_q <= '0;
         end

         if (capture) begin
            data_q <= {data_q[DATA_WIDTH-2:0], adc_miso};
         end

         // Loaded on the edge entering DONE, so it is visible with ready.
         if (frame_end) begin
            sample_q <= sample_next;
         end
      end
   end

endmodule

// File: tb/tb_adc_serial_rx.sv
// Self-checking bench for adc_serial_rx at default parameters.
// An ADC model shifts a 16-bit frame word out MSB first, one bit per sclk
// rising edge; a reference model derives the expected sample from the frame
// word arithmetically (and averages the last four under ADC_AVG_EN).
module tb_adc_serial_rx;

   localparam int unsigned CD   = 4;
   localparam int unsigned FB   = 16;
   localparam int unsigned LEAD = 3;
   localparam int unsigned DW   = 10;
   localparam int READY_LAT    = 1 + CD + 2 * CD * FB;   // 133
   // start held high: IDLE lasts one cycle after QUIET before restarting
   localparam int FRAME_PERIOD = 134 + 2 * CD;           // 142

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          adc_miso = 1'b0;
   logic          adc_cs_n;
   logic          adc_sclk;
   logic [DW-1:0] sample;
   logic          ready;
   logic          busy;

   int tests = 0;
   int fails = 0;

   adc_serial_rx #(
      .CLK_DIV   (CD),
      .FRAME_BITS(FB),
      .LEAD_BITS (LEAD),
      .DATA_WIDTH(DW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .adc_miso(adc_miso),
      .adc_cs_n(adc_cs_n),
      .adc_sclk(adc_sclk),
      .sample  (sample),
      .ready   (ready),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1);
   end

   // ADC model: frame bit rise_cnt is on adc_miso until the next sclk rise.
   logic [FB-1:0] adc_word = '0;
   int unsigned   rise_cnt = 0;
   logic          prev_sclk = 1'b1;
   logic          prev_cs   = 1'b1;

   always @(negedge clk) begin
      if (prev_cs && !adc_cs_n) begin
         rise_cnt = 0;
      end else if (!adc_cs_n && !prev_sclk && adc_sclk) begin
         rise_cnt = rise_cnt + 1;
      end
      prev_sclk = adc_sclk;
      prev_cs   = adc_cs_n;
      adc_miso  = (rise_cnt < FB) ? adc_word[FB-1-rise_cnt] : 1'b0;
   end

   // Reference model
   logic [DW-1:0] mhist [3];

   function automatic logic [DW-1:0] extract(input logic [FB-1:0] w);
      int unsigned v;
      v = w;
      v = (v >> (FB - LEAD - DW)) % (1 << DW);
      return DW'(v);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) mhist[i] = '0;
   endtask

   task automatic model_push(input logic [DW-1:0] raw, output logic [DW-1:0] expv);
`ifdef ADC_AVG_EN
      int unsigned sum;
      sum  = raw + mhist[0] + mhist[1] + mhist[2];
      expv = DW'(sum / 4);
`else
      expv = raw;
`endif
      mhist[2] = mhist[1];
      mhist[1] = mhist[0];
      mhist[0] = raw;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   logic [DW-1:0] prev_sample = '0;
   logic          prev_ready  = 1'b0;

   // One clk cycle; also checks sample only moves with ready and ready is a single-cycle pulse.
   task automatic step();
      @(negedge clk);
      if (!rst) begin
         if (sample !== prev_sample) check("sample_moves_only_with_ready", ready, 1'b1);
         if (prev_ready) check("ready_single_cycle", ready, 1'b0);
      end
      prev_sample = sample;
      prev_ready  = ready;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 40) begin
         step();
         n++;
      end
      check({tag, "_returns_idle"}, busy, 1'b0);
   endtask

   task automatic run_frame(input string tag, input logic [FB-1:0] word, input logic [DW-1:0] raw);
      int c;
      int cs_bad;
      bit seen;
      logic [DW-1:0] expv;
      adc_word = word;
      start = 1'b1;
      step();
      start = 1'b0;
      c = 1;
      cs_bad = 0;
      seen = 1'b0;
      while (c <= 400) begin
         if (ready) begin
            seen = 1'b1;
            break;
         end
         if (adc_cs_n !== 1'b0) cs_bad++;
         step();
         c++;
      end
      check({tag, "_ready_seen"}, seen, 1'b1);
      check({tag, "_ready_latency"}, c, READY_LAT);
      check({tag, "_cs_low_cycles_missing"}, cs_bad, 0);
      check({tag, "_cs_high_at_ready"}, adc_cs_n, 1'b1);
      check({tag, "_sclk_rises"}, rise_cnt, FB);
      model_push(raw, expv);
      check({tag, "_sample"}, sample, expv);
      wait_idle(tag);
   endtask

   typedef struct {
      logic [FB-1:0] word;
      logic [DW-1:0] raw;
   } vec_t;

   vec_t vecs [7];

   initial begin
      logic [FB-1:0] w;
      logic [DW-1:0] expv;
      logic [FB-1:0] hw [3];
      logic [DW-1:0] hraw [3];
      int rc [3];
      int nr;
      int c;

      vecs[0] = '{{3'b000, 10'b1011001101, 3'b000}, 10'h2CD};
      vecs[1] = '{{3'b111, 10'h3FF, 3'b111}, 10'h3FF};
      vecs[2] = '{{3'b101, 10'h000, 3'b010}, 10'h000};
      vecs[3] = '{{3'b000, 10'h155, 3'b000}, 10'h155};
      vecs[4] = '{{3'b111, 10'h200, 3'b000}, 10'h200};
      vecs[5] = '{{3'b000, 10'h001, 3'b111}, 10'h001};
      vecs[6] = '{{3'b010, 10'h2AA, 3'b101}, 10'h2AA};

      rst = 1'b1;
      start = 1'b0;
      model_reset();
      repeat (3) step();
      check("reset_cs_n", adc_cs_n, 1'b1);
      check("reset_sclk", adc_sclk, 1'b1);
      check("reset_busy", busy, 1'b0);
      rst = 1'b0;

      // Idle after reset
      c = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (adc_cs_n !== 1'b1 || ready !== 1'b0 || busy !== 1'b0) c++;
      end
      check("idle_disturbed_cycles", c, 0);
      check("idle_cs_n", adc_cs_n, 1'b1);
      check("idle_sclk", adc_sclk, 1'b1);
      check("idle_ready", ready, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_sample", sample, 0);

      // Table-driven frames (entry 0 is the 0x2CD reference frame)
      for (int i = 0; i < 7; i++) begin
         run_frame($sformatf("vec%0d", i), vecs[i].word, vecs[i].raw);
      end

      // Random frames, lead/trail bits random too
      for (int i = 0; i < 6; i++) begin
         w = FB'($urandom);
         run_frame($sformatf("rand%0d", i), w, extract(w));
      end

      // Second start arrives while busy and must be dropped
      adc_word = {3'b110, 10'h1A5, 3'b011};
      start = 1'b1;
      step();
      start = 1'b0;
      nr = 0;
      for (int cc = 1; cc <= 320; cc++) begin
         if (ready) begin
            nr++;
            model_push(extract(adc_word), expv);
            check("busy_start_sample", sample, expv);
         end
         start = (cc == 50);
         step();
      end
      check("busy_start_ready_count", nr, 1);
      check("busy_start_idle_after", busy, 1'b0);

      // start held high: three back-to-back frames
      hw[0] = {3'b101, 10'h3FF, 3'b110};
      hw[1] = {3'b111, 10'h000, 3'b111};
      hw[2] = {3'b000, 10'h155, 3'b001};
      for (int i = 0; i < 3; i++) begin
         hraw[i] = extract(hw[i]);
         rc[i] = 0;
      end
      adc_word = hw[0];
      start = 1'b1;
      step();
      nr = 0;
      for (int cc = 1; cc <= 3 * FRAME_PERIOD + 40; cc++) begin
         if (ready && nr < 3) begin
            rc[nr] = cc;
            check("held_sclk_rises", rise_cnt, FB);
            model_push(hraw[nr], expv);
            check($sformatf("held_sample%0d", nr), sample, expv);
            nr++;
            if (nr < 3) adc_word = hw[nr];
            else start = 1'b0;
         end
         step();
      end
      start = 1'b0;
      check("held_ready_count", nr, 3);
      check("held_first_latency", rc[0], READY_LAT);
      check("held_spacing_1", rc[1] - rc[0], FRAME_PERIOD);
      check("held_spacing_2", rc[2] - rc[1], FRAME_PERIOD);
      wait_idle("held");

      // Reset in the middle of a frame
      adc_word = {3'b000, 10'h3C3, 3'b000};
      start = 1'b1;
      step();
      start = 1'b0;
      for (int cc = 1; cc < 70; cc++) step();
      check("abort_midframe_busy", busy, 1'b1);
      rst = 1'b1;
      step();
      check("abort_cs_n", adc_cs_n, 1'b1);
      check("abort_sclk", adc_sclk, 1'b1);
      check("abort_busy", busy, 1'b0);
      check("abort_ready", ready, 1'b0);
      check("abort_sample", sample, 0);
      model_reset();
      rst = 1'b0;
      nr = 0;
      for (int cc = 0; cc < 200; cc++) begin
         step();
         if (ready) nr++;
      end
      check("abort_no_ready", nr, 0);
      run_frame("after_abort", {3'b011, 10'h0F0, 3'b100}, 10'h0F0);

`ifdef ADC_AVG_EN
      // Averaging ramp from a cleared history
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_reset();
      step();
      run_frame("avg1", {3'b000, 10'h100, 3'b000}, 10'h100);
      check("avg1_const", sample, 10'h040);
      run_frame("avg2", {3'b000, 10'h100, 3'b000}, 10'h100);
      check("avg2_const", sample, 10'h080);
      run_frame("avg3", {3'b000, 10'h100, 3'b000}, 10'h100);
      check("avg3_const", sample, 10'h0C0);
      run_frame("avg4", {3'b000, 10'h100, 3'b000}, 10'h100);
      check("avg4_const", sample, 10'h100);
      run_frame("avg5", {3'b000, 10'h200, 3'b000}, 10'h200);
      check("avg5_const", sample, 10'h140);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
